// File: rtl/r2r_dac_sequencer.sv
// Waveform sequencer for the 4-bit R2R DAC ladder: ramp, triangle, square or
// direct level, stepped by a programmable divider and configured over a small register port.
module r2r_dac_sequencer #(
  parameter int DIV_W   = 8,
  parameter int SQ_HALF = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [7:0]       cfg_wdata,
  output logic [7:0]       cfg_rdata,
  output logic [3:0]       drive_bit,
  output logic             step_strobe,
  output logic [2:0]       dbg_state
);

  // Config port protocol: there is no valid/ready pair. cfg_we is a strobe that is
  // always accepted; each cycle with cfg_we=1 commits exactly one write on that edge.
  // cfg_rdata is a combinational view of the register selected by cfg_addr.

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_DIV    = 2'd1;
  localparam logic [1:0] ADDR_LEVELS = 2'd2;
  localparam logic [1:0] ADDR_DIRECT = 2'd3;

  localparam logic [1:0] MODE_RAMP   = 2'd0;
  localparam logic [1:0] MODE_TRI    = 2'd1;
  localparam logic [1:0] MODE_SQUARE = 2'd2;
  localparam logic [1:0] MODE_DIRECT = 2'd3;

  localparam logic [7:0] SQ_LAST = 8'(SQ_HALF - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RAMP   = 3'd1,
    S_TRI_UP = 3'd2,
    S_TRI_DN = 3'd3,
    S_SQ_HI  = 3'd4,
    S_SQ_LO  = 3'd5,
    S_DIRECT = 3'd6
  } state_t;

  state_t             state, state_nxt;
  logic [2:0]         ctrl;
  logic [DIV_W-1:0]   div;
  logic [7:0]         levels;
  logic [3:0]         direct;
  logic [DIV_W-1:0]   div_cnt, div_cnt_nxt;
  logic [7:0]         sq_cnt, sq_cnt_nxt;
  logic [3:0]         drive_nxt;
  logic               strobe_nxt;

  logic               wr_ctrl, wr_div, wr_levels, wr_direct;
  logic               restart, running, tick;
  logic [2:0]         eff_ctrl;
  logic [7:0]         eff_levels;
  logic [3:0]         eff_direct;
  logic [7:0]         div_rd;

  assign wr_ctrl   = cfg_we && (cfg_addr == ADDR_CTRL);
  assign wr_div    = cfg_we && (cfg_addr == ADDR_DIV);
  assign wr_levels = cfg_we && (cfg_addr == ADDR_LEVELS);
  assign wr_direct = cfg_we && (cfg_addr == ADDR_DIRECT);

  // Restart and level updates must use the value being written this cycle.
  assign eff_ctrl   = wr_ctrl   ? cfg_wdata[2:0] : ctrl;
  assign eff_levels = wr_levels ? cfg_wdata      : levels;
  assign eff_direct = wr_direct ? cfg_wdata[3:0] : direct;

  assign restart = wr_ctrl || wr_div;
  assign running = (state == S_RAMP)   || (state == S_TRI_UP) || (state == S_TRI_DN) ||
                   (state == S_SQ_HI)  || (state == S_SQ_LO);
  assign tick    = running && (div_cnt == div);

  assign dbg_state = state;

  always_comb begin
    div_rd            = '0;
    div_rd[DIV_W-1:0] = div;
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      ADDR_CTRL:   cfg_rdata = {5'b0, ctrl};
      ADDR_DIV:    cfg_rdata = div_rd;
      ADDR_LEVELS: cfg_rdata = levels;
      default:     cfg_rdata = {4'b0, direct};
    endcase
  end

  always_comb begin
    state_nxt   = state;
    drive_nxt   = drive_bit;
    strobe_nxt  = 1'b0;
    div_cnt_nxt = div_cnt;
    sq_cnt_nxt  = sq_cnt;

    if (restart) begin
      // A restart discards any tick in the same cycle.
      div_cnt_nxt = '0;
      sq_cnt_nxt  = '0;
      if (!eff_ctrl[0]) begin
        state_nxt = S_IDLE;
        drive_nxt = 4'd0;
      end else begin
        case (eff_ctrl[2:1])
          MODE_RAMP: begin
            state_nxt = S_RAMP;
            drive_nxt = 4'd0;
          end
          MODE_TRI: begin
            state_nxt = S_TRI_UP;
            drive_nxt = 4'd0;
          end
          MODE_SQUARE: begin
            state_nxt = S_SQ_HI;
            drive_nxt = eff_levels[7:4];
          end
          default: begin
            state_nxt = S_DIRECT;
            drive_nxt = eff_direct;
          end
        endcase
      end
    end else begin
      div_cnt_nxt = (!running || tick) ? '0 : div_cnt + 1'b1;
      case (state)
        S_RAMP: begin
          if (tick) begin
            drive_nxt  = drive_bit + 4'd1;
            strobe_nxt = 1'b1;
          end
        end
        S_TRI_UP: begin
          if (tick) begin
            strobe_nxt = 1'b1;
            if (drive_bit == 4'd15) begin
              state_nxt = S_TRI_DN;
              drive_nxt = 4'd14;
            end else begin
              drive_nxt = drive_bit + 4'd1;
            end
          end
        end
        S_TRI_DN: begin
          if (tick) begin
            strobe_nxt = 1'b1;
            if (drive_bit == 4'd0) begin
              state_nxt = S_TRI_UP;
              drive_nxt = 4'd1;
            end else begin
              drive_nxt = drive_bit - 4'd1;
            end
          end
        end
        S_SQ_HI: begin
          // Re-reading the level every cycle lets a LEVELS write land without restart.
          drive_nxt = eff_levels[7:4];
          if (tick) begin
            if (sq_cnt == SQ_LAST) begin
              state_nxt  = S_SQ_LO;
              drive_nxt  = eff_levels[3:0];
              sq_cnt_nxt = '0;
              strobe_nxt = 1'b1;
            end else begin
              sq_cnt_nxt = sq_cnt + 8'd1;
            end
          end
        end
        S_SQ_LO: begin
          drive_nxt = eff_levels[3:0];
          if (tick) begin
            if (sq_cnt == SQ_LAST) begin
              state_nxt  = S_SQ_HI;
              drive_nxt  = eff_levels[7:4];
              sq_cnt_nxt = '0;
              strobe_nxt = 1'b1;
            end else begin
              sq_cnt_nxt = sq_cnt + 8'd1;
            end
          end
        end
        S_DIRECT: drive_nxt = eff_direct;
        default:  drive_nxt = 4'd0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      ctrl   <= '0;
      div    <= '0;
      levels <= '0;
      direct <= '0;
    end else if (cfg_we) begin
      case (cfg_addr)
        ADDR_CTRL:   ctrl   <= cfg_wdata[2:0];
        ADDR_DIV:    div    <= cfg_wdata[DIV_W-1:0];
        ADDR_LEVELS: levels <= cfg_wdata;
        default:     direct <= cfg_wdata[3:0];
      endcase
    end
  end

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      state       <= S_IDLE;
      drive_bit   <= '0;
      step_strobe <= 1'b0;
      div_cnt     <= '0;
      sq_cnt      <= '0;
    end else begin
      state       <= state_nxt;
      drive_bit   <= drive_nxt;
      step_strobe <= strobe_nxt;
      div_cnt     <= div_cnt_nxt;
      sq_cnt      <= sq_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_r2r_dac_sequencer.sv
// Directed bench for r2r_dac_sequencer: a vector table for register/direct behaviour
// plus hand-written sequences for ramp, triangle, square, restart and reset.
module tb_r2r_dac_sequencer;

  logic       clk;
  logic       n_rst;
  logic       cfg_we;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_wdata;
  logic [7:0] cfg_rdata;
  logic [3:0] drive_bit;
  logic       step_strobe;
  logic [2:0] dbg_state;

  int n_vec = 0;
  int n_err = 0;

  r2r_dac_sequencer #(.DIV_W(8), .SQ_HALF(8)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_wdata   (cfg_wdata),
    .cfg_rdata   (cfg_rdata),
    .drive_bit   (drive_bit),
    .step_strobe (step_strobe),
    .dbg_state   (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic [3:0] exp_drive;
    logic       exp_strobe;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic [3:0] exp_drive, input logic exp_strobe);
    check({name, " drive"}, 8'(drive_bit), 8'(exp_drive));
    check({name, " strobe"}, 8'(step_strobe), 8'(exp_strobe));
  endtask

  // Every step leaves the bench 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    step();
    cfg_we    = 1'b0;
  endtask

  initial begin
    logic [3:0] tv;
    logic       up;
    logic       hi;

    vecs[0]  = '{1'b1, 2'd0, 8'h07, 4'd0,  1'b0, 8'h07};
    vecs[1]  = '{1'b1, 2'd3, 8'h0A, 4'd10, 1'b0, 8'h0A};
    vecs[2]  = '{1'b0, 2'd3, 8'h00, 4'd10, 1'b0, 8'h0A};
    vecs[3]  = '{1'b1, 2'd3, 8'h05, 4'd5,  1'b0, 8'h05};
    vecs[4]  = '{1'b0, 2'd0, 8'h00, 4'd5,  1'b0, 8'h07};
    vecs[5]  = '{1'b1, 2'd0, 8'hFF, 4'd5,  1'b0, 8'h07};
    vecs[6]  = '{1'b1, 2'd1, 8'hFF, 4'd5,  1'b0, 8'hFF};
    vecs[7]  = '{1'b1, 2'd2, 8'hFF, 4'd5,  1'b0, 8'hFF};
    vecs[8]  = '{1'b1, 2'd3, 8'hFF, 4'd15, 1'b0, 8'h0F};
    vecs[9]  = '{1'b0, 2'd0, 8'h00, 4'd15, 1'b0, 8'h07};
    vecs[10] = '{1'b1, 2'd0, 8'h00, 4'd0,  1'b0, 8'h00};
    vecs[11] = '{1'b0, 2'd1, 8'h00, 4'd0,  1'b0, 8'hFF};

    // Reset
    n_rst = 1'b1; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_out("reset", 4'd0, 1'b0);
    check("reset state", 8'(dbg_state), 8'd0);
    for (int a = 0; a < 4; a++) begin
      cfg_addr = 2'(a);
      #1;
      check($sformatf("reset rdata[%0d]", a), cfg_rdata, 8'h00);
    end
    n_rst = 1'b0;
    step();
    check_out("idle", 4'd0, 1'b0);

    // Ramp, DIV=0: one step per cycle
    wr(2'd1, 8'h00);
    wr(2'd0, 8'h01);
    check_out("ramp start", 4'd0, 1'b0);
    for (int k = 1; k <= 17; k++) begin
      step();
      check_out($sformatf("ramp[%0d]", k), 4'(k % 16), 1'b1);
    end

    // Triangle, DIV=3: step every 4 cycles
    wr(2'd1, 8'h03);
    wr(2'd0, 8'h03);
    check_out("tri start", 4'd0, 1'b0);
    tv = 4'd0; up = 1'b1;
    for (int k = 1; k <= 128; k++) begin
      step();
      if (k % 4 == 0) begin
        if (up) begin
          if (tv == 4'd15) begin up = 1'b0; tv = 4'd14; end
          else tv = tv + 4'd1;
        end else begin
          if (tv == 4'd0) begin up = 1'b1; tv = 4'd1; end
          else tv = tv - 4'd1;
        end
      end
      check_out($sformatf("tri[%0d]", k), tv, (k % 4 == 0));
    end

    // Square, LEVELS=0xC3, DIV=1, SQ_HALF=8: 16 cycles per phase
    wr(2'd2, 8'hC3);
    wr(2'd1, 8'h01);
    wr(2'd0, 8'h05);
    check_out("sq start", 4'd12, 1'b0);
    for (int k = 1; k <= 64; k++) begin
      step();
      hi = ((k / 16) % 2 == 0);
      check_out($sformatf("sq[%0d]", k), hi ? 4'd12 : 4'd3, (k % 16 == 0));
    end
    // LEVELS write mid-phase: high phase takes the new level without restart
    wr(2'd2, 8'h5A);
    check_out("sq levels upd", 4'd5, 1'b0);
    for (int k = 66; k <= 80; k++) begin
      step();
      check_out($sformatf("sq2[%0d]", k), (k == 80) ? 4'd10 : 4'd5, (k == 80));
    end

    // Direct mode and readback table
    for (int i = 0; i < 12; i++) begin
      cfg_we    = vecs[i].we;
      cfg_addr  = vecs[i].addr;
      cfg_wdata = vecs[i].wdata;
      step();
      check_out($sformatf("vec[%0d]", i), vecs[i].exp_drive, vecs[i].exp_strobe);
      check($sformatf("vec[%0d] rdata", i), cfg_rdata, vecs[i].exp_rdata);
    end
    cfg_we = 1'b0;

    // Ramp DIV=2, CTRL write in a tick cycle restarts and drops the tick
    wr(2'd1, 8'h02);
    wr(2'd0, 8'h01);
    check_out("rr start", 4'd0, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      step();
      check_out($sformatf("rr[%0d]", k), 4'(k / 3), (k % 3 == 0));
    end
    wr(2'd0, 8'h01);
    check_out("rr restart", 4'd0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      step();
      check_out($sformatf("rr2[%0d]", k), (k >= 3) ? 4'd1 : 4'd0, (k == 3));
    end

    // Asynchronous reset mid-ramp clears everything immediately
    n_rst = 1'b1;
    #1;
    check_out("async rst", 4'd0, 1'b0);
    for (int a = 0; a < 4; a++) begin
      cfg_addr = 2'(a);
      #1;
      check($sformatf("async rst rdata[%0d]", a), cfg_rdata, 8'h00);
    end
    step();
    n_rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      check_out($sformatf("post rst idle[%0d]", k), 4'd0, 1'b0);
    end
    wr(2'd0, 8'h01);
    check_out("resume", 4'd0, 1'b0);
    step();
    check_out("resume step", 4'd1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
